// File: rtl/joybus_tx_pkg.sv
// Shared joybus constants: FSM states, per-phase unit counts and the byte payload type.
// The receive side derives its pulse-width thresholds from the same unit counts.
package joybus_tx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TICK_W = 6;
  localparam int unsigned QTR_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_STOP_LOW,
    ST_STOP_HIGH,
    ST_FINISH
  } state_e;

  localparam logic [QTR_W-1:0] BIT0_LOW  = 2'd3;
  localparam logic [QTR_W-1:0] BIT0_HIGH = 2'd1;
  localparam logic [QTR_W-1:0] BIT1_LOW  = 2'd1;
  localparam logic [QTR_W-1:0] BIT1_HIGH = 2'd3;
  localparam logic [QTR_W-1:0] CSTOP_LOW = 2'd1;
  localparam logic [QTR_W-1:0] KSTOP_LOW = 2'd2;
  localparam logic [QTR_W-1:0] STOP_HIGH = 2'd2;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_byte_t;

  function automatic logic [QTR_W-1:0] low_units(input logic b);
    return b ? BIT1_LOW : BIT0_LOW;
  endfunction

  function automatic logic [QTR_W-1:0] high_units(input logic b);
    return b ? BIT1_HIGH : BIT0_HIGH;
  endfunction

endpackage

// File: rtl/joybus_tx_if.sv
// Byte-stream handshake into the joybus transmitter.
interface joybus_tx_if;
  import joybus_tx_pkg::*;

  logic              tx_valid;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);

endinterface

// File: rtl/joybus_phase_timer.sv
// Counts one waveform phase of units*QUARTER_TICKS clocks; expire marks its last clock.
// expire_next_c predicts expire for the following clock so the caller can register tx_ready.
module joybus_phase_timer
  import joybus_tx_pkg::*;
#(
  parameter int unsigned QUARTER_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [QTR_W-1:0] units,
  output logic             expire,
  output logic             expire_next_c
);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(QUARTER_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_NEAR   = TICK_W'((QUARTER_TICKS > 1) ? QUARTER_TICKS - 2 : 0);
  localparam bit                SINGLE_TICK = (QUARTER_TICKS == 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [QTR_W-1:0]  qtr_q, qtr_d;
  logic [QTR_W-1:0]  units_q, units_d;
  logic              qtr_last_c;

  assign qtr_last_c = (qtr_q == units_q - 2'd1);
  assign expire     = (tick_q == TICK_LAST) && qtr_last_c;

  always_comb begin
    tick_d  = tick_q;
    qtr_d   = qtr_q;
    units_d = units_q;
    if (start) begin
      tick_d  = '0;
      qtr_d   = '0;
      units_d = units;
    end else if (tick_q == TICK_LAST) begin
      tick_d = '0;
      qtr_d  = qtr_last_c ? '0 : qtr_q + 2'd1;
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end
  end

  // A restart this clock makes the next clock the first of the new phase.
  always_comb begin
    expire_next_c = 1'b0;
    if (start) begin
      expire_next_c = SINGLE_TICK && (units == 2'd1);
    end else if (SINGLE_TICK) begin
      expire_next_c = (qtr_q == units_q - 2'd2);
    end else begin
      expire_next_c = (tick_q == TICK_NEAR) && qtr_last_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q  <= '0;
      qtr_q   <= '0;
      units_q <= 2'd1;
    end else begin
      tick_q  <= tick_d;
      qtr_q   <= qtr_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/joybus_tx.sv
// Joybus transmitter: serialises bytes MSB first into 1:3 / 3:1 pulse-width bits,
// chains back-to-back bytes without a gap and closes each frame with a stop bit.
module joybus_tx
  import joybus_tx_pkg::*;
#(
  parameter int unsigned QUARTER_TICKS = 4,
  parameter int unsigned STOP_STYLE    = 0
) (
  input  logic          clk,
  input  logic          reset,
  joybus_tx_if.slave    tx,
  output logic          line_low,
  output logic          tx_active,
  output logic          done,
  output logic          underrun
);

  localparam logic [QTR_W-1:0] STOP_LOW_UNITS = (STOP_STYLE == 0) ? CSTOP_LOW : KSTOP_LOW;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              last_q, last_d;
  logic              tx_ready_q, tx_ready_d;
  logic              line_low_q, line_low_d;
  logic              tx_active_q, tx_active_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;

  logic              hs_c;
  logic              load_c;
  logic              tmr_start_c;
  logic [QTR_W-1:0]  tmr_units_c;
  logic              tmr_expire;
  logic              tmr_expire_next_c;
  tx_byte_t          in_byte_c;

  assign in_byte_c   = '{last: tx.tx_last, data: tx.tx_data};
  assign hs_c        = tx.tx_valid && tx_ready_q;
  assign tx.tx_ready = tx_ready_q;
  assign line_low    = line_low_q;
  assign tx_active   = tx_active_q;
  assign done        = done_q;
  assign underrun    = underrun_q;

  joybus_phase_timer #(
    .QUARTER_TICKS (QUARTER_TICKS)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .start         (tmr_start_c),
    .units         (tmr_units_c),
    .expire        (tmr_expire),
    .expire_next_c (tmr_expire_next_c)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    last_d      = last_q;
    load_c      = 1'b0;
    tmr_start_c = 1'b0;
    tmr_units_c = BIT0_LOW;
    underrun_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: load_c = hs_c;
      ST_BIT_LOW: begin
        if (tmr_expire) begin
          state_d     = ST_BIT_HIGH;
          tmr_start_c = 1'b1;
          tmr_units_c = high_units(shift_q[BYTE_W-1]);
        end
      end
      ST_BIT_HIGH: begin
        if (tmr_expire) begin
          if (bit_idx_q != '0) begin
            shift_d     = {shift_q[BYTE_W-2:0], 1'b0};
            bit_idx_d   = bit_idx_q - IDX_W'(1);
            state_d     = ST_BIT_LOW;
            tmr_start_c = 1'b1;
            tmr_units_c = low_units(shift_q[BYTE_W-2]);
          end else if (last_q) begin
            state_d     = ST_STOP_LOW;
            tmr_start_c = 1'b1;
            tmr_units_c = STOP_LOW_UNITS;
          end else if (hs_c) begin
            load_c = 1'b1;
          end else begin
            // Source ran dry mid-frame: end the frame with a proper stop bit.
            underrun_d  = 1'b1;
            state_d     = ST_STOP_LOW;
            tmr_start_c = 1'b1;
            tmr_units_c = STOP_LOW_UNITS;
          end
        end
      end
      ST_STOP_LOW: begin
        if (tmr_expire) begin
          state_d     = ST_STOP_HIGH;
          tmr_start_c = 1'b1;
          tmr_units_c = STOP_HIGH;
        end
      end
      ST_STOP_HIGH: begin
        if (tmr_expire) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (load_c) begin
      shift_d     = in_byte_c.data;
      last_d      = in_byte_c.last;
      bit_idx_d   = IDX_W'(BYTE_W - 1);
      state_d     = ST_BIT_LOW;
      tmr_start_c = 1'b1;
      tmr_units_c = low_units(in_byte_c.data[BYTE_W-1]);
    end

    // Outputs are registered from the next state so they line up with it.
    line_low_d  = (state_d == ST_BIT_LOW) || (state_d == ST_STOP_LOW);
    tx_active_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d      = (state_d == ST_FINISH);
    tx_ready_d  = (state_d == ST_IDLE) ||
                  ((state_d == ST_BIT_HIGH) && (bit_idx_d == '0) && !last_d && tmr_expire_next_c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      last_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      line_low_q  <= 1'b0;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      last_q      <= last_d;
      tx_ready_q  <= tx_ready_d;
      line_low_q  <= line_low_d;
      tx_active_q <= tx_active_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_joybus_tx.sv
// Bench for joybus_tx: table of frames checked against a pulse-width waveform model,
// plus hand sequences for reset, mid-frame reset and controller-style stop.
module tb_joybus_tx;

  localparam int QT      = 4;
  localparam int BIT_CLK = 4 * QT;

  logic clk = 1'b0;
  logic reset;
  logic ll0, act0, done0, und0;
  logic llk, actk, donek, undk;

  joybus_tx_if txi ();
  joybus_tx_if txk ();

  joybus_tx #(.QUARTER_TICKS(QT), .STOP_STYLE(0)) u_dut (
    .clk(clk), .reset(reset), .tx(txi),
    .line_low(ll0), .tx_active(act0), .done(done0), .underrun(und0)
  );

  joybus_tx #(.QUARTER_TICKS(QT), .STOP_STYLE(1)) u_dut_k (
    .clk(clk), .reset(reset), .tx(txk),
    .line_low(llk), .tx_active(actk), .done(donek), .underrun(undk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected line level at sample k after the accept edge (console stop).
  function automatic logic exp_line(input logic [7:0] b0, input logic [7:0] b1,
                                    input int n, input int k);
    int bitn, pos, s;
    logic [7:0] cur;
    bitn = (k - 1) / BIT_CLK;
    pos  = (k - 1) % BIT_CLK;
    if (bitn < 8 * n) begin
      cur = (bitn < 8) ? b0 : b1;
      if (cur[7 - (bitn % 8)]) return pos < QT;
      return pos < 3 * QT;
    end
    s = k - 1 - 8 * n * BIT_CLK;
    return s < QT;
  endfunction

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         n;
    logic       fin_last;
    int         exp_done;
    int         exp_low;
    int         exp_rdy;
    int         exp_und;
  } vec_t;

  vec_t vecs [5];

  int          done_at, und_at, und_cnt, ready_pulses, low_cnt, act_cnt, wave_err, dec_n;
  logic [15:0] dec_word;

  // Send one frame of n bytes on the console-stop instance and record what the line did.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input int n, input logic fin_last);
    int   guard, nacc, run;
    logic prev;
    done_at = -1; und_at = -1; und_cnt = 0; ready_pulses = 0;
    low_cnt = 0; act_cnt = 0; wave_err = 0; dec_n = 0; dec_word = '0;
    run = 0; prev = 1'b0;
    @(negedge clk);
    txi.tx_valid = 1'b1;
    txi.tx_data  = b0;
    txi.tx_last  = (n == 1) ? fin_last : 1'b0;
    guard = 0;
    while (!txi.tx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", int'(txi.tx_ready), 1);
    nacc = 1;
    for (int k = 1; k < 700 && done_at < 0; k++) begin
      @(negedge clk);
      if (nacc >= n) txi.tx_valid = 1'b0;
      else if (k == 1) begin
        txi.tx_data = b1;
        txi.tx_last = fin_last;
      end
      if (txi.tx_ready) begin
        ready_pulses++;
        if (txi.tx_valid) nacc++;
      end
      if (ll0) low_cnt++;
      if (act0) act_cnt++;
      if (ll0 !== exp_line(b0, b1, n, k)) wave_err++;
      if (ll0) run = prev ? run + 1 : 1;
      if (!ll0 && prev && dec_n < 8 * n) begin
        dec_word = {dec_word[14:0], (run < 2 * QT)};
        dec_n++;
      end
      prev = ll0;
      if (und0) begin
        und_at = k;
        und_cnt++;
      end
      if (done0) done_at = k;
    end
    txi.tx_valid = 1'b0;
  endtask

  initial begin
    int guard, k_done, stop_low, lows_after, dones_after;
    logic [15:0] exp_dec;

    // Sample index 0 is the accept clock, so "142 clk accept..done" means done at sample 141.
    vecs[0] = '{b0: 8'h00, b1: 8'h00, n: 1, fin_last: 1'b1, exp_done: 141, exp_low: 100, exp_rdy: 0, exp_und: -1};
    vecs[1] = '{b0: 8'hFF, b1: 8'h00, n: 1, fin_last: 1'b1, exp_done: 141, exp_low: 36,  exp_rdy: 0, exp_und: -1};
    vecs[2] = '{b0: 8'hA5, b1: 8'h3C, n: 2, fin_last: 1'b1, exp_done: 269, exp_low: 132, exp_rdy: 1, exp_und: -1};
    vecs[3] = '{b0: 8'h80, b1: 8'h00, n: 1, fin_last: 1'b0, exp_done: 141, exp_low: 92,  exp_rdy: 1, exp_und: 129};
    vecs[4] = '{b0: 8'h01, b1: 8'h00, n: 1, fin_last: 1'b1, exp_done: 141, exp_low: 92,  exp_rdy: 0, exp_und: -1};

    txi.tx_valid = 1'b0; txi.tx_data = '0; txi.tx_last = 1'b0;
    txk.tx_valid = 1'b0; txk.tx_data = '0; txk.tx_last = 1'b0;
    reset = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_line_low",  int'(ll0), 0);
    check("rst_tx_active", int'(act0), 0);
    check("rst_done",      int'(done0), 0);
    check("rst_underrun",  int'(und0), 0);
    check("rst_tx_ready",  int'(txi.tx_ready), 0);
    check("rst_k_line",    int'(llk), 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(txi.tx_ready), 1);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].b0, vecs[i].b1, vecs[i].n, vecs[i].fin_last);
      exp_dec = (vecs[i].n == 2) ? {vecs[i].b0, vecs[i].b1} : {8'h00, vecs[i].b0};
      check($sformatf("v%0d done_at", i),      done_at, vecs[i].exp_done);
      check($sformatf("v%0d low_cycles", i),   low_cnt, vecs[i].exp_low);
      check($sformatf("v%0d ready_pulses", i), ready_pulses, vecs[i].exp_rdy);
      check($sformatf("v%0d underrun_at", i),  und_at, vecs[i].exp_und);
      check($sformatf("v%0d underrun_cnt", i), und_cnt, (vecs[i].exp_und < 0) ? 0 : 1);
      check($sformatf("v%0d wave_errors", i),  wave_err, 0);
      check($sformatf("v%0d decoded", i),      int'(dec_word), int'(exp_dec));
      check($sformatf("v%0d active_cycles", i), act_cnt, vecs[i].exp_done - 1);
    end

    // Mid-frame reset during byte 0x55: frame abandoned, no stop bit, no done.
    @(negedge clk);
    txi.tx_valid = 1'b1; txi.tx_data = 8'h55; txi.tx_last = 1'b1;
    guard = 0;
    while (!txi.tx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      txi.tx_valid = 1'b0;
    end
    check("pre_reset_active", int'(act0), 1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_line_low",  int'(ll0), 0);
    check("midrst_tx_active", int'(act0), 0);
    check("midrst_done",      int'(done0), 0);
    check("midrst_tx_ready",  int'(txi.tx_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_release", int'(txi.tx_ready), 1);
    lows_after = 0; dones_after = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ll0) lows_after++;
      if (done0) dones_after++;
    end
    check("midrst_no_stop", lows_after, 0);
    check("midrst_no_done", dones_after, 0);
    run_frame(8'h01, 8'h00, 1, 1'b1);
    check("post_rst_done_at", done_at, 141);
    check("post_rst_wave",    wave_err, 0);
    check("post_rst_decoded", int'(dec_word), 16'h0001);

    // Controller-style stop on byte 0x00: 2 units low.
    @(negedge clk);
    txk.tx_valid = 1'b1; txk.tx_data = 8'h00; txk.tx_last = 1'b1;
    guard = 0;
    while (!txk.tx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("k_accept_ready", int'(txk.tx_ready), 1);
    k_done = -1; stop_low = 0;
    for (int k = 1; k < 400 && k_done < 0; k++) begin
      @(negedge clk);
      txk.tx_valid = 1'b0;
      if (k > 8 * BIT_CLK && llk) stop_low++;
      if (undk) stop_low += 100;
      if (donek) begin
        k_done = k;
        check("k_active_at_done", int'(actk), 0);
      end
    end
    check("k_stop_low", stop_low, 8);
    check("k_done_at", k_done, 145);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/joybus_tx.md
Name: joybus_tx

Overview:
- Transmit half of the fake-N64 joybus link: serialises bytes into the pulse-width waveform decoded on the receive side.
- Encoding per bit: '0' = 3 units low, 1 unit high; '1' = 1 unit low, 3 units high.
- Drives an open-drain enable. The line is pulled high externally when released.
- Sits beside the receiver. Its tx_active output selects the shared cur_operation (1 = Tx, 0 = Rx).

Parameters:
- QUARTER_TICKS, 4: clk cycles per protocol unit (1 us at 4 MHz). Legal range 1..63.
- STOP_STYLE, 0: 0 = console stop (1 unit low, 2 units high); 1 = controller stop (2 units low, 2 units high).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- tx_valid  in  1  byte available.
- tx_data  in  8  byte to send, MSB first.
- tx_last  in  1  qualifies tx_data as final byte of frame.
- tx_ready  out  1  byte accepted on clk edge where tx_valid && tx_ready.
- line_low  out  1  1 = pull joybus line low; 0 = release.
- tx_active  out  1  high from first accepted byte until stop bit completes.
- done  out  1  one-cycle pulse after stop bit.
- underrun  out  1  one-cycle pulse when a non-last byte is not followed by data in time.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; outputs line_low=0, tx_active=0, done=0, underrun=0, tx_ready=0.
  - tx_ready rises on the first clock after reset is released.
  - Reset mid-frame releases the line on that same edge. No stop bit is sent.
- States: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH, FINISH.
- Registers: shift[7:0], bit_idx[2:0], last_flag, tick counter[5:0], quarter counter[1:0].
- IDLE:
  - tx_ready=1, line_low=0.
  - On handshake: load shift and last_flag, bit_idx=7, go BIT_LOW.
  - line_low=1 and tx_active=1 from the next cycle, so accept-to-line latency is 1 clock.
- BIT_LOW:
  - line_low=1 for (shift[7] ? 1 : 3) * QUARTER_TICKS clocks, then BIT_HIGH.
- BIT_HIGH:
  - line_low=0 for (shift[7] ? 3 : 1) * QUARTER_TICKS clocks. Every bit is exactly 4*QUARTER_TICKS clocks.
  - At its final clock with bit_idx>0: shift left, bit_idx--, go BIT_LOW.
  - At its final clock with bit_idx==0:
    - last_flag=1: go STOP_LOW.
    - last_flag=0, tx_ready=1 in this final clock only, handshake: reload and go BIT_LOW, giving back-to-back bytes with no gap.
    - last_flag=0, no tx_valid: pulse underrun, go STOP_LOW (frame terminated cleanly).
- STOP_LOW:
  - line_low=1 for 1 unit (STOP_STYLE=0) or 2 units (STOP_STYLE=1).
- STOP_HIGH:
  - line_low=0 for 2 units, then FINISH.
- FINISH:
  - done=1 and tx_active=0 for one cycle, then IDLE (tx_ready=1 the following cycle).
- tx_ready is 0 in every state and clock not listed above. tx_valid outside a ready clock is ignored, with no latching.
- tx_data and tx_last are sampled only at the handshake edge.
- Tick counting: the counter counts 0..(n*QUARTER_TICKS - 1) per phase and clears on every phase change. No wrap carries across phases.
- Output timing: line_low is a registered output driven directly from state, so it is glitch-free.

Decomposition:
- Shared include joybus_defs.vh holds:
  - state encodings;
  - unit counts: BIT0_LOW=3, BIT0_HIGH=1, BIT1_LOW=1, BIT1_HIGH=3, CSTOP_LOW=1, KSTOP_LOW=2, STOP_HIGH=2.
  - The receiver's thresholds derive from the same constants.
- One sub-module, joybus_phase_timer:
  - inputs: clk, reset, start, units[1:0] (1..3);
  - output: expire pulse on the last clock of units*QUARTER_TICKS.

Test Plan (QUARTER_TICKS=4, STOP_STYLE=0):
- Single byte 0x00, tx_last=1 -> 8x(line_low 12 clk, released 4 clk), then low 4, released 8, done pulse. Total 142 clk from accept to done.
- Single byte 0xFF, tx_last=1 -> 8x(low 4, released 12), same stop. Frame length is identical to 0x00.
- Two bytes 0xA5 then 0x3C (last), second valid held -> tx_ready pulses exactly once, on the final clock of 0xA5 bit 0. No gap between bytes. Bit pattern 1010010100111100 is recovered by the receiver.
- Byte 0x80 non-last, tx_valid dropped -> underrun pulse on the final bit's last clock, then stop bit, then done.
- reset=0 at clock 30 of 0x55 frame -> line_low=0 on that edge, tx_active=0, no done. After release, a new 0x01 frame sends correctly.
- STOP_STYLE=1, byte 0x00 -> stop low is 8 clk instead of 4.
